// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 slave backed by a register-array memory, with independent write and read FSMs
module axi4_mem_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int ID_WIDTH = 4
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_areset,
    input  logic [ID_WIDTH-1:0]         s_axi_awid,
    input  logic [ADDR_BUS_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [DATA_BUS_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_BUS_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [ID_WIDTH-1:0]         s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [ID_WIDTH-1:0]         s_axi_arid,
    input  logic [ADDR_BUS_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [ID_WIDTH-1:0]         s_axi_rid,
    output logic [DATA_BUS_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready
);
    localparam int AW = ADDR_BUS_WIDTH;
    localparam int BYTES = DATA_BUS_WIDTH / 8;
    localparam int LSB = $clog2(BYTES);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
    localparam logic [AW-1:0] SPAN = AW'(MEM_DEPTH * BYTES);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_BUS_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic in_range(input logic [AW-1:0] a);
        return a >= BASE && (a - BASE) < SPAN;
    endfunction

    function automatic logic [IW-1:0] idx(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - BASE;
        return off[LSB +: IW];
    endfunction

    function automatic logic legal(input logic [2:0] s, input logic [1:0] b, input logic [7:0] l);
        return s == 3'(LSB) && b != 2'b11 &&
               (b != 2'b10 || l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15);
    endfunction

    // WRAP keeps the upper bits of the (len+1)*BYTES window and increments only inside it
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [1:0] b, input logic [7:0] l);
        logic [AW-1:0] al, m;
        al = a & ~AW'(BYTES - 1);
        m = ((AW'(l) + AW'(1)) << LSB) - AW'(1);
        return b == 2'b00 ? a : b == 2'b10 ? (al & ~m) | ((al + AW'(BYTES)) & m) : al + AW'(BYTES);
    endfunction

    w_state_t w_state, w_next;
    logic [AW-1:0] w_addr;
    logic [7:0] w_len, w_cnt;
    logic [1:0] w_burst;
    logic w_ill, w_dec, w_lerr;
    logic aw_hs, w_hs, b_hs, w_last;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs = s_axi_wvalid && s_axi_wready;
    assign b_hs = s_axi_bvalid && s_axi_bready;
    assign w_last = w_cnt == w_len;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: w_next = aw_hs ? W_DATA : W_IDLE;
            W_DATA: w_next = (w_hs && w_last) ? W_RESP : W_DATA;
            W_RESP: w_next = b_hs ? W_IDLE : W_RESP;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp <= 2'b00;
            s_axi_bid <= '0;
        end else begin
            w_state <= w_next;
            s_axi_awready <= w_next == W_IDLE;
            s_axi_wready <= w_next == W_DATA;
            s_axi_bvalid <= w_next == W_RESP;
            if (aw_hs) begin
                s_axi_bid <= s_axi_awid;
                w_addr <= s_axi_awaddr;
                w_len <= s_axi_awlen;
                w_burst <= s_axi_awburst;
                w_ill <= !legal(s_axi_awsize, s_axi_awburst, s_axi_awlen);
                w_cnt <= 8'd0;
                w_dec <= 1'b0;
                w_lerr <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_burst, w_len);
                w_cnt <= w_cnt + 8'd1;
                w_dec <= w_dec || !in_range(w_addr);
                w_lerr <= w_lerr || (s_axi_wlast != w_last);
                if (w_last)
                    s_axi_bresp <= (w_dec || !in_range(w_addr)) ? 2'b11 :
                                   (w_ill || w_lerr || !s_axi_wlast) ? 2'b10 : 2'b00;
            end
        end
    end

    always_ff @(posedge s_axi_aclk)
        if (!s_axi_areset && w_hs && !w_ill && in_range(w_addr))
            for (int i = 0; i < BYTES; i++)
                if (s_axi_wstrb[i]) mem[idx(w_addr)][8*i +: 8] <= s_axi_wdata[8*i +: 8];

    r_state_t r_state, r_next;
    logic [AW-1:0] r_addr, rb_addr;
    logic [7:0] r_len, r_cnt, rb_len, rb_cnt;
    logic [1:0] r_burst, rb_burst;
    logic r_ill, rb_ill, rb_out, ar_hs, r_hs, r_load;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs = s_axi_rvalid && s_axi_rready;
    assign r_load = ar_hs || (r_hs && !s_axi_rlast);
    // Beat 0 is sourced straight from the AR channel; later beats from the latched request
    assign rb_addr = r_state == R_IDLE ? s_axi_araddr : r_addr;
    assign rb_len = r_state == R_IDLE ? s_axi_arlen : r_len;
    assign rb_burst = r_state == R_IDLE ? s_axi_arburst : r_burst;
    assign rb_cnt = r_state == R_IDLE ? 8'd0 : r_cnt;
    assign rb_ill = r_state == R_IDLE ? !legal(s_axi_arsize, s_axi_arburst, s_axi_arlen) : r_ill;
    assign rb_out = !in_range(rb_addr);

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: r_next = ar_hs ? R_DATA : R_IDLE;
            R_DATA: r_next = (r_hs && s_axi_rlast) ? R_IDLE : R_DATA;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rlast <= 1'b0;
            s_axi_rresp <= 2'b00;
            s_axi_rdata <= '0;
            s_axi_rid <= '0;
        end else begin
            r_state <= r_next;
            s_axi_arready <= r_next == R_IDLE;
            s_axi_rvalid <= r_next == R_DATA;
            if (ar_hs) begin
                s_axi_rid <= s_axi_arid;
                r_len <= s_axi_arlen;
                r_burst <= s_axi_arburst;
                r_ill <= rb_ill;
            end
            if (r_load) begin
                s_axi_rdata <= (rb_ill || rb_out) ? '0 : mem[idx(rb_addr)];
                s_axi_rresp <= rb_ill ? 2'b10 : rb_out ? 2'b11 : 2'b00;
                s_axi_rlast <= rb_cnt == rb_len;
                r_addr <= next_addr(rb_addr, rb_burst, rb_len);
                r_cnt <= rb_cnt + 8'd1;
            end
        end
    end
endmodule
